// File: rtl/input_conditioner.sv
// Input conditioner: per-bit synchronizer, N-cycle debounce and registered edge pulses.
// Every output is driven directly by a flop; all bits are fully independent.
module input_conditioner #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
    logic [WIDTH-1:0]                  sync_q;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  clean_q, clean_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // NOTE: every next-state value gets a default first, so no bit can hold
    // through an unassigned path and infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Accepted transition: the counter restarts so the next one needs a full window.
                clean_d[i] = sync_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync_q[i];
                fall_d[i]  = ~sync_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments; the synchronizer
    // shift depends on each stage reading its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain_q <= '0;
            cnt_q        <= '0;
            clean_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], raw_in};
            cnt_q        <= cnt_d;
            clean_q      <= clean_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: expected pulse events are queued when raw_in is driven
// and popped when the DUT pulses; a second DEBOUNCE_CYCLES=1 instance covers that boundary.
module tb_input_conditioner;

    localparam int SS  = 2;
    localparam int DC  = 4;
    localparam int LAT = SS + DC;

    typedef struct {
        int         edge_no;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] clean;
    } ev_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [1:0] raw_in = 2'b00;
    logic [1:0] clean_out, rise_pulse, fall_pulse;
    logic       clean1, rise1, fall1;

    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulse  = 0;
    int   n_rise1  = 0;
    int   n_fall1  = 0;
    logic [1:0] exp_clean = 2'b00;
    ev_t  sb[$];
    ev_t  mon_ev;

    input_conditioner #(.WIDTH(2), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    input_conditioner #(.WIDTH(1), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in[0]),
        .clean_out  (clean1),
        .rise_pulse (rise1),
        .fall_pulse (fall1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    endtask

    // Every pulse seen on the main DUT must match the oldest queued event.
    always @(negedge clk) begin
        if (rise1 === 1'b1) n_rise1 <= n_rise1 + 1;
        if (fall1 === 1'b1) n_fall1 <= n_fall1 + 1;
        if ((rise_pulse | fall_pulse) != 2'b00) begin
            n_pulse <= n_pulse + 1;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {rise_pulse, fall_pulse}, 0);
            end else begin
                mon_ev = sb.pop_front();
                check("pulse_edge",  edge_cnt,   mon_ev.edge_no);
                check("pulse_rise",  rise_pulse, mon_ev.rise);
                check("pulse_fall",  fall_pulse, mon_ev.fall);
                check("pulse_clean", clean_out,  mon_ev.clean);
            end
        end
    end

    task automatic run_to(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    // Drive a stable raw value and check the level just before, at and after acceptance.
    task automatic step(input string tag, input logic [1:0] v);
        int b;
        b = edge_cnt;
        if (v != exp_clean) sb.push_back('{b + LAT, v & ~exp_clean, exp_clean & ~v, v});
        raw_in = v;
        run_to(b + LAT - 1);
        check({tag, "_pre"}, clean_out, exp_clean);
        run_to(b + LAT);
        check({tag, "_clean"}, clean_out, v);
        run_to(b + LAT + 1);
        check({tag, "_pulse_off"}, {rise_pulse, fall_pulse}, 0);
        exp_clean = v;
    endtask

    initial begin
        int b, p0, r0, f0;
        logic [1:0] v;

        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_clean", clean_out, 0);
            check("rst_rise",  rise_pulse, 0);
            check("rst_fall",  fall_pulse, 0);
        end
        rst = 1'b0;
        step("rise01", 2'b01);

        // Two 3-edge glitches on bit 1 must both be rejected.
        for (int g = 0; g < 2; g++) begin
            raw_in = 2'b11;
            run_to(edge_cnt + 3);
            check("glitch_hold", clean_out, 1);
            raw_in = 2'b01;
            run_to(edge_cnt + 2);
        end
        run_to(edge_cnt + 8);
        check("glitch_after", clean_out, 1);

        step("rise10", 2'b11);
        step("fall01", 2'b10);
        step("fall10", 2'b00);
        step("both",   2'b11);
        step("to10",   2'b10);

        // Asynchronous reset mid-cycle while bit 0 is half-way through its debounce.
        b = edge_cnt;
        raw_in = 2'b11;
        run_to(b + 4);
        rst = 1'b1;
        #1;
        check("midrst_clean", clean_out, 0);
        check("midrst_pulse", {rise_pulse, fall_pulse}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_clean = 2'b00;
        step("midrst_rel", 2'b01);

        p0 = n_pulse;
        r0 = n_rise1;
        f0 = n_fall1;
        for (int k = 0; k < 8; k++) begin
            b = edge_cnt;
            v = exp_clean ^ 2'b01;
            sb.push_back('{b + LAT, v & ~exp_clean, exp_clean & ~v, v});
            raw_in = v;
            run_to(b + 2);
            check("d1_old", clean1, exp_clean[0]);
            run_to(b + 3);
            check("d1_new", clean1, v[0]);
            run_to(b + 8);
            exp_clean = v;
        end
        run_to(edge_cnt + 4);
        check("tog_pulses", n_pulse - p0, 8);
        check("d1_rises",   n_rise1 - r0, 4);
        check("d1_falls",   n_fall1 - f0, 4);
        check("tog_clean",  clean_out, 1);
        check("sb_empty",   sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that cleans raw asynchronous inputs before they reach the downstream register/logic stage (the A/B inputs of that stage).
- Per bit, the block:
  - synchronizes the input to clk,
  - debounces it by requiring N consecutive stable cycles,
  - emits single-cycle rise and fall pulses.
- One instance covers all WIDTH lines; every bit is fully independent.

Parameters:
- WIDTH, 2, number of independent input lines (bit 0 = A, bit 1 = B in the default use).
- SYNC_STAGES, 2, synchronizer flop depth; legal values >= 2.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized value must differ from clean_out before clean_out updates; legal values >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- raw_in  input  WIDTH  unsynchronized external inputs.
- clean_out  output  WIDTH  debounced, synchronized level.
- rise_pulse  output  WIDTH  one-cycle pulse when clean_out goes 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse when clean_out goes 1->0.

Behaviour:
- Reset:
  - rst high immediately clears all state asynchronously: sync flops, counters, clean_out, rise_pulse, fall_pulse all become 0.
  - Deassertion is taken at the next clk edge; the first edge with rst low is the first functional edge.
- Synchronizer:
  - Per bit, a chain of SYNC_STAGES flops.
  - sync_q (the last stage) reflects raw_in sampled SYNC_STAGES-1 edges earlier.
- Debounce counter: per bit, width max(1, clog2(DEBOUNCE_CYCLES)). On each edge:
  - sync_q == clean_out: cnt <= 0, clean_out holds.
  - sync_q != clean_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync_q != clean_out and cnt == DEBOUNCE_CYCLES-1: clean_out <= sync_q, cnt <= 0.
- Latency:
  - A raw change that stays stable updates clean_out on edge number SYNC_STAGES+DEBOUNCE_CYCLES.
  - Edge 1 is the first edge that samples the new raw value.
  - Defaults: 6th edge.
- Glitch rejection:
  - If sync_q returns to the clean_out value before the counter expires, the counter clears and no output changes.
  - A later disturbance restarts the count from 0.
- Pulses:
  - Registered. rise_pulse[i] goes high on the same edge that clean_out[i] goes 0->1 and low on the following edge; fall_pulse mirrors this for 1->0.
  - Exactly one cycle high per accepted transition.
  - rise and fall never assert together on the same bit.
- Back-to-back transitions:
  - Minimum spacing between accepted transitions on one bit is DEBOUNCE_CYCLES edges, because the counter restarts at 0 after each update.
  - Pulses for consecutive transitions are never merged.
- DEBOUNCE_CYCLES = 1: clean_out follows sync_q with one edge of delay; pulses still fire once per change.
- Multi-bit: bits may transition on the same edge; each bit's pulse asserts independently.
- Reset mid-debounce: the count is discarded; after release the debounce restarts from clean_out = 0.
- No combinational path from raw_in to any output; all outputs come directly from flops.

Test Plan (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset and stable rise:
  - Stimulus: rst high 3 cycles, outputs all 0; release rst, then raw_in=2'b01 held before edge 1.
  - Required: clean_out=2'b01 after edge 6; rise_pulse=2'b01 for exactly the cycle after edge 6, then 0; fall_pulse stays 0.
- Glitch rejection:
  - Stimulus: clean_out=0; raw_in[1] high for 3 edges, then low.
  - Required: clean_out[1] and rise_pulse[1] stay 0 throughout; a second 3-edge glitch 2 cycles later is also rejected.
- Fall transition:
  - Stimulus: clean_out=2'b11; raw_in=2'b10 held.
  - Required: clean_out=2'b10 on edge 6; fall_pulse=2'b01 for one cycle; bit 1 untouched, no pulses on it.
- Simultaneous bits:
  - Stimulus: raw_in 2'b00->2'b11 on the same edge.
  - Required: both bits update on edge 6; rise_pulse=2'b11 for one cycle.
- Reset mid-debounce:
  - Stimulus: raw_in[0]=1, rst pulsed asynchronously (mid-cycle) after edge 4.
  - Required: clean_out and counters read 0 immediately; with raw held at 1, clean_out[0] rises on the 6th edge after release, plus one rise_pulse.
- Toggle stress:
  - Stimulus: raw_in[0] toggles every 8 edges for 64 edges.
  - Required: every accepted transition gives exactly one pulse of the correct polarity; there are 8 pulses total, alternating rise and fall.
